// File: rtl/light_bar_gen.sv
// rtl/light_bar_gen.sv - two-stage VGA pixel generator for the segmented turn-signal light bar
module light_bar_gen #(
    parameter int          COUNTER_BITS = 10,
    parameter int          NUM_SEG      = 10,
    parameter int          X0           = 50,
    parameter int          SEG_W        = 50,
    parameter int          GAP          = 40,
    parameter int          Y0           = 200,
    parameter int          BAR_H        = 80,
    parameter int          ACC_H        = 10,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [7:0]  DIM_LEVEL    = 8'h80
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bright,
    input  logic [COUNTER_BITS-1:0] h_count,
    input  logic [COUNTER_BITS-1:0] v_count,
    input  logic [NUM_SEG-1:0]      seg_on,
    input  logic [1:0]              mode,
    output logic [7:0]              red_out,
    output logic [7:0]              green_out,
    output logic [7:0]              blue_out
);
    localparam int W    = COUNTER_BITS + 1;
    localparam int HALF = NUM_SEG / 2;
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [W-1:0] BAR_LO = W'(Y0);
    localparam logic [W-1:0] BAR_HI = W'(Y0 + BAR_H - 1);
    localparam logic [W-1:0] ACC_LO = W'(Y0 + BAR_H);
    localparam logic [W-1:0] ACC_HI = W'(Y0 + BAR_H + ACC_H - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [NUM_SEG-1:0] pattern_q, pattern_d;
    logic [1:0]         mode_q, mode_d;
    logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic               origin_q, origin_d;

    logic               bar_q, bar_d;
    logic               acc_l_q, acc_l_d;
    logic               acc_r_q, acc_r_d;
    logic               bright_q, bright_d;
    logic [7:0]         level_q, level_d;

    logic [7:0]         red_q, red_d;
    logic [7:0]         green_q, green_d;
    logic [7:0]         blue_q, blue_d;

    logic [W-1:0]       x_ext, y_ext;
    logic [NUM_SEG-1:0] seg_hit;
    logic               lit_l, lit_r, in_bar, in_acc, origin_evt;

    assign x_ext = {1'b0, h_count};
    assign y_ext = {1'b0, v_count};

    // Right-half segments keep their index-based position plus the GAP shift.
    for (genvar i = 0; i < NUM_SEG; i++) begin : g_seg
        localparam int           LO   = X0 + i * SEG_W + ((i >= HALF) ? GAP : 0);
        localparam logic [W-1:0] LO_W = W'(LO);
        localparam logic [W-1:0] HI_W = W'(LO + SEG_W - 1);
        assign seg_hit[i] = pattern_q[i] && (x_ext >= LO_W) && (x_ext <= HI_W);
    end

    assign lit_l  = |seg_hit[HALF-1:0];
    assign lit_r  = |seg_hit[NUM_SEG-1:HALF];
    assign in_bar = (y_ext >= BAR_LO) && (y_ext <= BAR_HI);
    assign in_acc = (y_ext >= ACC_LO) && (y_ext <= ACC_HI);

    always_comb begin
        origin_d      = (h_count == '0) && (v_count == '0);
        origin_evt    = origin_d && !origin_q;
        pattern_d     = pattern_q;
        mode_d        = mode_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (origin_evt) begin
            pattern_d = seg_on;
            mode_d    = mode;
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = !blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        case (mode_q)
            2'b00:   level_d = 8'hFF;
            2'b01:   level_d = blink_phase_q ? 8'h00 : 8'hFF;
            2'b10:   level_d = DIM_LEVEL;
            default: level_d = 8'h00;
        endcase
        bar_d    = in_bar && (lit_l || lit_r);
        acc_l_d  = in_acc && lit_l;
        acc_r_d  = in_acc && lit_r;
        bright_d = bright;

        red_d   = (bright_q && bar_q)   ? level_q : 8'h00;
        green_d = (bright_q && acc_r_q) ? level_q : 8'h00;
        blue_d  = (bright_q && acc_l_q) ? level_q : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_q     <= '0;
            mode_q        <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            origin_q      <= 1'b0;
            bar_q         <= 1'b0;
            acc_l_q       <= 1'b0;
            acc_r_q       <= 1'b0;
            bright_q      <= 1'b0;
            level_q       <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            pattern_q     <= pattern_d;
            mode_q        <= mode_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            origin_q      <= origin_d;
            bar_q         <= bar_d;
            acc_l_q       <= acc_l_d;
            acc_r_q       <= acc_r_d;
            bright_q      <= bright_d;
            level_q       <= level_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign red_out   = red_q;
    assign green_out = green_q;
    assign blue_out  = blue_q;
endmodule

// File: tb/tb_light_bar_gen.sv
// tb/tb_light_bar_gen.sv - directed and randomized checks of light_bar_gen against a geometric model
module tb_light_bar_gen;
    localparam int BF      = 2;
    localparam int NSEG    = 10;
    localparam int HALF    = NSEG / 2;
    localparam int X0      = 50;
    localparam int SEG_W   = 50;
    localparam int GAP     = 40;
    localparam int Y0      = 200;
    localparam int BAR_H   = 80;
    localparam int ACC_H   = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bright = 1'b1;
    logic [9:0]  h_count = 10'd5;
    logic [9:0]  v_count = 10'd5;
    logic [9:0]  seg_on = '0;
    logic [1:0]  mode = '0;
    logic [7:0]  red_out, green_out, blue_out;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [9:0]  m_pat = '0;
    logic [1:0]  m_mode = '0;
    int          m_ev = 0;

    light_bar_gen #(.BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .bright(bright),
        .h_count(h_count), .v_count(v_count),
        .seg_on(seg_on), .mode(mode),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out)
    );

    always #5 clk = ~clk;

    // Colour a pixel should get, from the geometric description of the bar.
    function automatic logic [23:0] model(int x, int y, bit b, logic [9:0] pat,
                                          logic [1:0] md, int ev);
        int   seg;
        bit   right;
        logic [7:0] lv;
        seg   = -1;
        right = 0;
        if (!b) return 24'h0;
        if (x >= X0 && x < X0 + HALF * SEG_W) begin
            seg = (x - X0) / SEG_W;
        end else if (x >= X0 + HALF * SEG_W + GAP && x < X0 + NSEG * SEG_W + GAP) begin
            seg   = (x - X0 - GAP) / SEG_W;
            right = 1;
        end
        if (seg < 0) return 24'h0;
        if (!pat[seg]) return 24'h0;
        case (md)
            2'd0:    lv = 8'hFF;
            2'd1:    lv = (((ev / BF) % 2) == 1) ? 8'h00 : 8'hFF;
            2'd2:    lv = 8'h80;
            default: lv = 8'h00;
        endcase
        if (y >= Y0 && y < Y0 + BAR_H) return {lv, 16'h0};
        if (y >= Y0 + BAR_H && y < Y0 + BAR_H + ACC_H)
            return right ? {8'h0, lv, 8'h0} : {16'h0, lv};
        return 24'h0;
    endfunction

    task automatic chk(string tag, logic [23:0] exp);
        logic [23:0] obs;
        obs = {red_out, green_out, blue_out};
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: rgb got %h expected %h", tag, obs, exp);
    endtask

    task automatic origin(logic [9:0] s, logic [1:0] m, int hold);
        @(negedge clk);
        seg_on = s; mode = m; h_count = 10'd0; v_count = 10'd0;
        repeat (hold) @(negedge clk);
        m_pat = s; m_mode = m; m_ev++;
        h_count = 10'd1;
        seg_on = ~s;
        mode = ~m;
    endtask

    task automatic pix(int x, int y, bit b, string tag, logic [23:0] exp);
        @(negedge clk);
        h_count = 10'(x); v_count = 10'(y); bright = b;
        @(negedge clk);
        @(negedge clk);
        chk(tag, exp);
        bright = 1'b1;
    endtask

    task automatic pixm(int x, int y, string tag);
        pix(x, y, 1'b1, tag, model(x, y, 1'b1, m_pat, m_mode, m_ev));
    endtask

    initial begin
        logic [23:0] expq[$];
        int x, y;
        bit b;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 24'h0);
        rst = 1'b0;
        pix(60, 210, 1'b1, "no_pattern_yet", 24'h0);

        origin(10'h001, 2'd0, 1);
        pix(60, 210, 1'b1, "seg0_bar", 24'hFF0000);
        pix(60, 285, 1'b1, "seg0_acc", 24'h0000FF);
        pix(110, 210, 1'b1, "seg1_off", 24'h0);

        origin(10'h200, 2'd0, 1);
        pix(580, 285, 1'b1, "seg9_acc", 24'h00FF00);
        pix(589, 210, 1'b1, "seg9_right_edge", 24'hFF0000);
        pix(590, 210, 1'b1, "past_seg9", 24'h0);

        origin(10'h010, 2'd0, 1);
        pix(299, 279, 1'b1, "seg4_corner", 24'hFF0000);
        pix(300, 279, 1'b1, "seg4_x_past", 24'h0);
        pix(299, 280, 1'b1, "seg4_acc_top", 24'h0000FF);
        pix(299, 290, 1'b1, "seg4_acc_past", 24'h0);

        origin(10'h000, 2'd0, 1);
        seg_on = 10'h3FF;
        pix(60, 210, 1'b1, "midframe_l", 24'h0);
        pix(500, 250, 1'b1, "midframe_r", 24'h0);
        origin(10'h3FF, 2'd0, 1);
        pix(60, 210, 1'b1, "full_l", 24'hFF0000);
        pix(560, 230, 1'b1, "full_r", 24'hFF0000);
        pix(60, 210, 1'b0, "not_bright", 24'h0);

        origin(10'h3FF, 2'd2, 1);
        pix(100, 220, 1'b1, "dim_bar", 24'h800000);
        pix(400, 285, 1'b1, "dim_acc_r", 24'h008000);
        origin(10'h3FF, 2'd3, 1);
        pix(100, 220, 1'b1, "forced_off", 24'h0);

        for (int f = 0; f < 6; f++) begin
            origin(10'h3FF, 2'd1, 1);
            pixm(60, 210, $sformatf("blink_f%0d", f));
        end
        origin(10'h3FF, 2'd1, 3);
        pixm(60, 210, "hold_origin_a");
        for (int f = 0; f < 2; f++) begin
            origin(10'h3FF, 2'd1, 1);
            pixm(60, 210, $sformatf("hold_origin_b%0d", f));
        end

        // Pipelined random pixels; seg_on/mode churn between origins must be ignored.
        for (int r = 0; r < 4; r++) begin
            origin(10'($urandom), 2'($urandom_range(2, 0)), 1);
            expq.delete();
            for (int i = 0; i < 102; i++) begin
                @(negedge clk);
                if (i >= 2) chk($sformatf("rand_r%0d_p%0d", r, i - 2), expq.pop_front());
                if (i < 100) begin
                    x = $urandom_range(700, 1);
                    y = $urandom_range(400, 0);
                    b = ($urandom_range(7, 0) != 0);
                    h_count = 10'(x); v_count = 10'(y); bright = b;
                    seg_on = 10'($urandom); mode = 2'($urandom);
                    expq.push_back(model(x, y, b, m_pat, m_mode, m_ev));
                end
            end
            bright = 1'b1;
        end

        origin(10'h3FF, 2'd0, 1);
        @(negedge clk);
        h_count = 10'd60; v_count = 10'd210;
        repeat (2) @(negedge clk);
        chk("pre_reset_lit", 24'hFF0000);
        #2 rst = 1'b1;
        #1 chk("async_reset_clear", 24'h0);
        m_pat = '0; m_mode = '0; m_ev = 0;
        @(negedge clk);
        rst = 1'b0;
        pix(60, 210, 1'b1, "post_reset_dark", 24'h0);
        origin(10'h002, 2'd0, 1);
        pix(120, 210, 1'b1, "post_reset_capture", 24'hFF0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
